// File: rtl/fibonacci_checker_if.sv
// Term stream between a Fibonacci generator (master) and its checker (slave).
// Lane 0 carries the earlier term; lane 1 the later one, valid only together with lane 0.
interface fibonacci_checker_if #(
  parameter int W = 16
);
  logic         in_vld0;
  logic         in_vld1;
  logic [W-1:0] in_num;
  logic [W-1:0] in_num2;
  logic         in_ready;

  modport master (
    output in_vld0, in_vld1, in_num, in_num2,
    input  in_ready
  );

  modport slave (
    input  in_vld0, in_vld1, in_num, in_num2,
    output in_ready
  );
endinterface

// File: rtl/fibonacci_checker.sv
// Checks a one- or two-term-per-cycle Fibonacci stream against the recurrence
// over received terms, with seed checking, saturating counters and halt-on-error.
module fibonacci_checker #(
  parameter int           W           = 16,
  parameter logic [W-1:0] SEED0       = 1,
  parameter logic [W-1:0] SEED1       = 1,
  parameter bit           CHECK_SEED  = 1'b1,
  parameter bit           STOP_ON_ERR = 1'b0,
  parameter int           CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  fibonacci_checker_if.slave  s_if,
  output logic [1:0]          mismatch,
  output logic                error,
  output logic [15:0]         err_cnt,
  output logic [CNT_W-1:0]    term_cnt,
  output logic [CNT_W-1:0]    first_err_idx,
  output logic                proto_err
);

  typedef enum logic [1:0] {ST_SEED0, ST_SEED1, ST_RUN, ST_HALT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_prev;
  logic [W-1:0]     r_last;
  logic [1:0]       r_mismatch;
  logic             r_error;
  logic [15:0]      r_err_cnt;
  logic [CNT_W-1:0] r_term_cnt;
  logic [CNT_W-1:0] r_first_err_idx;
  logic             r_proto_err;

  logic             w_ready;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_proto;
  logic             w_mis0;
  logic             w_mis1;
  logic [W-1:0]     w_exp0;
  logic [W-1:0]     w_exp1;
  logic [1:0]       w_n_acc;
  logic [1:0]       w_n_mis;

  function automatic logic [CNT_W-1:0] sat_add_cnt(input logic [CNT_W-1:0] a,
                                                    input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  function automatic logic [15:0] sat_add_err(input logic [15:0] a,
                                               input logic [1:0]  inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Clear blocks acceptance so a restart never consumes a term.
  assign w_acc0  = s_if.in_vld0 & w_ready & ~clear;
  assign w_acc1  = s_if.in_vld1 & s_if.in_vld0 & w_ready & ~clear;
  assign w_proto = s_if.in_vld1 & ~s_if.in_vld0 & w_ready & ~clear;
  assign w_exp0  = r_prev + r_last;
  assign w_exp1  = r_last + s_if.in_num;
  assign w_n_acc = {1'b0, w_acc0} + {1'b0, w_acc1};
  assign w_n_mis = {1'b0, w_mis0} + {1'b0, w_mis1};

  always_comb begin
    w_mis0 = 1'b0;
    w_mis1 = 1'b0;
    case (r_state)
      ST_SEED0: begin
        w_mis0 = CHECK_SEED && w_acc0 && (s_if.in_num  != SEED0);
        w_mis1 = CHECK_SEED && w_acc1 && (s_if.in_num2 != SEED1);
      end
      ST_SEED1: begin
        w_mis0 = CHECK_SEED && w_acc0 && (s_if.in_num != SEED1);
        w_mis1 = w_acc1 && (s_if.in_num2 != w_exp1);
      end
      ST_RUN: begin
        w_mis0 = w_acc0 && (s_if.in_num  != w_exp0);
        w_mis1 = w_acc1 && (s_if.in_num2 != w_exp1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_SEED0;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_SEED0;
    end else begin
      case (r_state)
        ST_SEED0: if (w_acc0) w_state_nxt = w_acc1 ? ST_RUN : ST_SEED1;
        ST_SEED1: if (w_acc0) w_state_nxt = ST_RUN;
        default:  ;
      endcase
      if (STOP_ON_ERR && (w_mis0 || w_mis1)) w_state_nxt = ST_HALT;
    end
  end

  always_comb begin
    w_ready = (r_state != ST_HALT);
  end

  assign s_if.in_ready = w_ready;

  // History always follows received terms, so a single bad term resynchronises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev          <= '0;
      r_last          <= '0;
      r_mismatch      <= 2'b00;
      r_error         <= 1'b0;
      r_err_cnt       <= 16'd0;
      r_term_cnt      <= '0;
      r_first_err_idx <= '0;
      r_proto_err     <= 1'b0;
    end else if (clear) begin
      r_prev          <= '0;
      r_last          <= '0;
      r_mismatch      <= 2'b00;
      r_error         <= 1'b0;
      r_err_cnt       <= 16'd0;
      r_term_cnt      <= '0;
      r_first_err_idx <= '0;
      r_proto_err     <= 1'b0;
    end else begin
      if (w_acc1) begin
        r_prev <= s_if.in_num;
        r_last <= s_if.in_num2;
      end else if (w_acc0) begin
        r_prev <= r_last;
        r_last <= s_if.in_num;
      end
      r_mismatch <= {w_mis1, w_mis0};
      r_err_cnt  <= sat_add_err(r_err_cnt, w_n_mis);
      r_term_cnt <= sat_add_cnt(r_term_cnt, w_n_acc);
      if (w_mis0 || w_mis1 || w_proto) r_error <= 1'b1;
      if (w_proto) r_proto_err <= 1'b1;
      if (!r_error && (w_mis0 || w_mis1 || w_proto))
        r_first_err_idx <= (w_mis1 && !w_mis0) ? r_term_cnt + CNT_W'(1) : r_term_cnt;
    end
  end

  assign mismatch      = r_mismatch;
  assign error         = r_error;
  assign err_cnt       = r_err_cnt;
  assign term_cnt      = r_term_cnt;
  assign first_err_idx = r_first_err_idx;
  assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Directed bench for fibonacci_checker: a default instance and a halt-on-error instance.
module tb_fibonacci_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        clear_h;
    logic [1:0]  mismatch,   mismatch_h;
    logic        error,      error_h;
    logic [15:0] err_cnt,    err_cnt_h;
    logic [31:0] term_cnt,   term_cnt_h;
    logic [31:0] first_idx,  first_idx_h;
    logic        proto_err,  proto_err_h;

    int n_checks = 0;
    int n_fail   = 0;

    int fib [26] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987,
                     1597, 2584, 4181, 6765, 10946, 17711, 28657, 46368, 9489, 55857};
    int bad [9]  = '{1, 1, 2, 3, 6, 8, 13, 21, 34};
    int bmis [9] = '{0, 0, 0, 0, 1, 1, 1, 0, 0};

    fibonacci_checker_if #(.W(16)) u_if ();
    fibonacci_checker_if #(.W(16)) u_if_h ();

    fibonacci_checker #(.W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .s_if(u_if.slave),
        .mismatch(mismatch), .error(error), .err_cnt(err_cnt), .term_cnt(term_cnt),
        .first_err_idx(first_idx), .proto_err(proto_err)
    );

    fibonacci_checker #(.W(16), .STOP_ON_ERR(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .clear(clear_h), .s_if(u_if_h.slave),
        .mismatch(mismatch_h), .error(error_h), .err_cnt(err_cnt_h), .term_cnt(term_cnt_h),
        .first_err_idx(first_idx_h), .proto_err(proto_err_h)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle on the default instance; returns at the sampling edge.
    task automatic step(input logic v0, input logic v1, input int a, input int b);
        u_if.in_vld0 = v0;
        u_if.in_vld1 = v1;
        u_if.in_num  = 16'(a);
        u_if.in_num2 = 16'(b);
        @(negedge clk);
    endtask

    task automatic step_h(input logic v0, input logic v1, input int a, input int b);
        u_if_h.in_vld0 = v0;
        u_if_h.in_vld1 = v1;
        u_if_h.in_num  = 16'(a);
        u_if_h.in_num2 = 16'(b);
        @(negedge clk);
    endtask

    task automatic do_clear();
        u_if.in_vld0 = 1'b0;
        u_if.in_vld1 = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        clear_h = 1'b0;
        u_if.in_vld0 = 1'b0;   u_if.in_vld1 = 1'b0;
        u_if.in_num  = 16'd0;  u_if.in_num2 = 16'd0;
        u_if_h.in_vld0 = 1'b0; u_if_h.in_vld1 = 1'b0;
        u_if_h.in_num  = 16'd0; u_if_h.in_num2 = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_ready",    64'(u_if.in_ready), 64'd1);
        check("rst_mismatch", 64'(mismatch),      64'd0);
        check("rst_error",    64'(error),         64'd0);
        check("rst_err_cnt",  64'(err_cnt),       64'd0);
        check("rst_term_cnt", 64'(term_cnt),      64'd0);
        check("rst_first",    64'(first_idx),     64'd0);
        check("rst_proto",    64'(proto_err),     64'd0);

        // Double-rate clean stream
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, fib[2*i], fib[2*i+1]);
            check($sformatf("dr_mis%0d", i), 64'(mismatch), 64'd0);
        end
        step(1'b0, 1'b0, 0, 0);
        check("dr_term_cnt", 64'(term_cnt), 64'd8);
        check("dr_error",    64'(error),    64'd0);
        check("dr_err_cnt",  64'(err_cnt),  64'd0);

        // Single-rate stream through 16-bit wrap
        do_clear();
        check("clr_term_cnt", 64'(term_cnt), 64'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, fib[i], 0);
            check($sformatf("sr_mis%0d", i), 64'(mismatch), 64'd0);
        end
        check("sr_term_cnt6", 64'(term_cnt), 64'd6);
        check("sr_err_cnt6",  64'(err_cnt),  64'd0);
        for (int i = 6; i < 26; i++) begin
            step(1'b1, 1'b0, fib[i], 0);
            check($sformatf("wrap_mis%0d", i), 64'(mismatch), 64'd0);
        end
        step(1'b0, 1'b0, 0, 0);
        check("wrap_term_cnt", 64'(term_cnt), 64'd26);
        check("wrap_error",    64'(error),    64'd0);

        // Corrupted term 4 with resynchronisation
        do_clear();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, bad[i], 0);
            check($sformatf("bad_mis%0d", i), 64'(mismatch), 64'(bmis[i]));
        end
        step(1'b0, 1'b0, 0, 0);
        check("bad_err_cnt",  64'(err_cnt),   64'd3);
        check("bad_first",    64'(first_idx), 64'd4);
        check("bad_error",    64'(error),     64'd1);
        check("bad_term_cnt", 64'(term_cnt),  64'd9);

        // Only lane 1 fails: index points at the lane-1 term
        do_clear();
        step(1'b1, 1'b1, 1, 1);
        step(1'b1, 1'b1, 2, 4);
        check("l1_mis",   64'(mismatch),  64'd2);
        step(1'b0, 1'b0, 0, 0);
        check("l1_first", 64'(first_idx), 64'd3);
        check("l1_cnt",   64'(err_cnt),   64'd1);

        // Halt on a bad seed pair
        step_h(1'b1, 1'b1, 1, 2);
        check("h_mis",   64'(mismatch_h),     64'd2);
        check("h_ready", 64'(u_if_h.in_ready), 64'd0);
        step_h(1'b1, 1'b1, 3, 5);
        step_h(1'b0, 1'b0, 0, 0);
        check("h_term_cnt", 64'(term_cnt_h),  64'd2);
        check("h_err_cnt",  64'(err_cnt_h),   64'd1);
        check("h_first",    64'(first_idx_h), 64'd1);
        clear_h = 1'b1;
        @(negedge clk);
        clear_h = 1'b0;
        check("h_clr_ready", 64'(u_if_h.in_ready), 64'd1);
        check("h_clr_term",  64'(term_cnt_h),      64'd0);
        check("h_clr_err",   64'(err_cnt_h),       64'd0);
        check("h_clr_error", 64'(error_h),         64'd0);

        // Protocol violation: lane 1 without lane 0
        do_clear();
        step(1'b0, 1'b1, 1, 1);
        check("p_proto",    64'(proto_err), 64'd1);
        check("p_error",    64'(error),     64'd1);
        check("p_term_cnt", 64'(term_cnt),  64'd0);
        check("p_mis",      64'(mismatch),  64'd0);
        step(1'b1, 1'b1, 1, 1);
        step(1'b0, 1'b0, 0, 0);
        check("p_term_cnt2", 64'(term_cnt), 64'd2);

        // Async reset pulse inside one cycle
        #2 rst_n = 1'b0;
        #1;
        check("ar_error", 64'(error),         64'd0);
        check("ar_proto", 64'(proto_err),     64'd0);
        check("ar_term",  64'(term_cnt),      64'd0);
        check("ar_ready", 64'(u_if.in_ready), 64'd1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        step(1'b1, 1'b1, 1, 1);
        check("ar_mis0", 64'(mismatch), 64'd0);
        step(1'b1, 1'b1, 2, 3);
        check("ar_mis1", 64'(mismatch), 64'd0);
        step(1'b0, 1'b0, 0, 0);
        check("ar_term4", 64'(term_cnt), 64'd4);
        check("ar_err",   64'(error),    64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
